// File: rtl/pw_pkg.sv
// Shared definitions for the password pipeline: terminator bytes, length limit,
// streamer state encoding and the terminator test used by the storage stage too.
package pw_pkg;

    localparam logic [7:0] EOL         = 8'h0A;
    localparam logic [7:0] EOF         = 8'h00;
    localparam int         MAX_LEN_DEF = 55;

    typedef enum logic [3:0] {
        S_IDLE,
        S_IDX_RD,
        S_IDX_WAIT,
        S_FIRST_RD,
        S_FIRST_WAIT,
        S_NEXT_RD,
        S_NEXT_WAIT,
        S_EMIT,
        S_DONE
    } pw_state_t;

    function automatic logic is_term(input logic [7:0] b);
        return (b == EOL) || (b == EOF);
    endfunction

endpackage

// File: rtl/password_streamer.sv
// Walks the password index table and streams each password's bytes one per
// handshake beat, with a one-byte lookahead (nxt) to flag the last byte.
module password_streamer
    import pw_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              table_ready,
    input  logic [31:0]       password_count,
    output logic              idx_rd_en,
    output logic [31:0]       idx_addr,
    input  logic [ADDR_W-1:0] idx_data,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_first,
    output logic              out_last,
    output logic [31:0]       out_index,
    output logic [5:0]        out_len,
    output logic              out_trunc,
    output logic              busy,
    output logic              done
);

    pw_state_t         r_state;
    pw_state_t         w_state_nxt;
    pw_state_t         w_adv_state;
    logic [31:0]       r_n;
    logic [31:0]       r_count;
    logic [ADDR_W-1:0] r_ptr;
    logic [7:0]        r_hold;
    logic [7:0]        r_nxt;
    logic [5:0]        r_len;

    logic              w_start_ok;
    logic              w_emit;
    logic              w_len_max;
    logic              w_nxt_term;
    logic              w_last;
    logic [31:0]       w_n_inc;

    assign w_start_ok  = start && table_ready && (r_state == S_IDLE || r_state == S_DONE);
    assign w_emit      = (r_state == S_EMIT);
    assign w_len_max   = (r_len == 6'(MAX_LEN));
    assign w_nxt_term  = is_term(r_nxt);
    assign w_last      = w_nxt_term || w_len_max;
    assign w_n_inc     = r_n + 32'd1;
    assign w_adv_state = (w_n_inc == r_count) ? S_DONE : S_IDX_RD;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok)
                    w_state_nxt = (password_count == 32'd0) ? S_DONE : S_IDX_RD;
            end
            S_IDX_RD:     w_state_nxt = S_IDX_WAIT;
            S_IDX_WAIT:   w_state_nxt = S_FIRST_RD;
            S_FIRST_RD:   w_state_nxt = S_FIRST_WAIT;
            S_FIRST_WAIT: w_state_nxt = is_term(mem_data) ? w_adv_state : S_NEXT_RD;
            S_NEXT_RD:    w_state_nxt = S_NEXT_WAIT;
            S_NEXT_WAIT:  w_state_nxt = S_EMIT;
            S_EMIT: begin
                if (out_ready)
                    w_state_nxt = w_last ? w_adv_state : S_NEXT_RD;
            end
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_count <= '0;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_nxt   <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_n     <= '0;
                        r_count <= password_count;
                    end
                end
                S_IDX_WAIT: r_ptr <= idx_data;
                S_FIRST_WAIT: begin
                    // An empty password skips straight to the next table entry.
                    if (is_term(mem_data)) begin
                        r_n <= w_n_inc;
                    end else begin
                        r_hold <= mem_data;
                        r_len  <= 6'd1;
                        r_ptr  <= r_ptr + ADDR_W'(1);
                    end
                end
                S_NEXT_WAIT: r_nxt <= mem_data;
                S_EMIT: begin
                    if (out_ready) begin
                        if (w_last) begin
                            r_n <= w_n_inc;
                        end else begin
                            r_hold <= r_nxt;
                            r_len  <= r_len + 6'd1;
                            r_ptr  <= r_ptr + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Beat fields are gated by EMIT so every output reads zero outside a beat.
    assign idx_rd_en = (r_state == S_IDX_RD);
    assign idx_addr  = idx_rd_en ? r_n : '0;
    assign mem_rd_en = (r_state == S_FIRST_RD) || (r_state == S_NEXT_RD);
    assign mem_addr  = mem_rd_en ? r_ptr : '0;
    assign out_valid = w_emit;
    assign out_data  = w_emit ? r_hold : '0;
    assign out_first = w_emit && (r_len == 6'd1);
    assign out_last  = w_emit && w_last;
    assign out_index = w_emit ? r_n : '0;
    assign out_len   = w_emit ? r_len : '0;
    assign out_trunc = w_emit && w_len_max && !w_nxt_term;
    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_password_streamer.sv
// Scoreboard bench for password_streamer: directed traversals with hand-written
// expected beats, checked by an independent monitor on each handshake.
module tb_password_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        table_ready = 1'b1;
    logic [31:0] password_count = '0;
    logic        idx_rd_en;
    logic [31:0] idx_addr;
    logic [31:0] idx_data = '0;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_first;
    logic        out_last;
    logic [31:0] out_index;
    logic [5:0]  out_len;
    logic        out_trunc;
    logic        busy;
    logic        done;

    password_streamer #(.ADDR_W(32), .MAX_LEN(55)) dut (
        .clk(clk), .rst(rst), .start(start), .table_ready(table_ready),
        .password_count(password_count),
        .idx_rd_en(idx_rd_en), .idx_addr(idx_addr), .idx_data(idx_data),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_first(out_first), .out_last(out_last), .out_index(out_index),
        .out_len(out_len), .out_trunc(out_trunc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem  [0:255];
    logic [31:0] itab [0:7];

    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= mem[mem_addr[7:0]];
        if (idx_rd_en) idx_data <= itab[idx_addr[2:0]];
    end

    typedef struct packed {
        logic [7:0]  d;
        logic        f;
        logic        l;
        logic [31:0] i;
        logic [5:0]  n;
        logic        t;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic f, input logic l,
                        input logic [31:0] i, input logic [5:0] n, input logic t);
        beat_t b;
        b = '{d: d, f: f, l: l, i: i, n: n, t: t};
        exp_q.push_back(b);
    endtask

    // Monitor: every accepted beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            beat_t act;
            beat_t exp;
            act = '{d: out_data, f: out_first, l: out_last, i: out_index, n: out_len, t: out_trunc};
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 128'(act), 128'(0));
            end else begin
                exp = exp_q.pop_front();
                check("beat", 128'(act), 128'(exp));
            end
        end
    end

    task automatic start_run(input logic [31:0] cnt);
        password_count = cnt;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done", 128'(done), 128'(1));
        check("queue_drained", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic wait_valid(input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("valid_seen", 128'(out_valid), 128'(1));
    endtask

    task automatic load_basic();
        mem[0] = "a"; mem[1] = "b"; mem[2] = "c"; mem[3] = 8'h0A;
        mem[4] = "d"; mem[5] = "e"; mem[6] = 8'h00;
        itab[0] = 32'd0; itab[1] = 32'd4;
    endtask

    task automatic push_basic();
        push("a", 1'b1, 1'b0, 32'd0, 6'd1, 1'b0);
        push("b", 1'b0, 1'b0, 32'd0, 6'd2, 1'b0);
        push("c", 1'b0, 1'b1, 32'd0, 6'd3, 1'b0);
        push("d", 1'b1, 1'b0, 32'd1, 6'd1, 1'b0);
        push("e", 1'b0, 1'b1, 32'd1, 6'd2, 1'b0);
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({idx_rd_en, idx_addr, mem_rd_en, mem_addr, out_valid, out_data,
                     out_first, out_last, out_index, out_len, out_trunc, busy, done});
    endfunction

    initial begin
        int k;
        logic [48:0] snap;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) itab[i] = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", all_outs(), 128'(0));
        rst = 1'b0;

        // Basic traversal, with start-to-read and start-to-first-beat latency
        load_basic();
        push_basic();
        start_run(2);
        @(negedge clk);
        check("idx_rd_after_start", 128'({idx_rd_en, idx_addr}), 128'({1'b1, 32'd0}));
        k = 1;
        while (!out_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("first_valid_latency", 128'(k), 128'(7));
        wait_done(200);

        // Backpressure: stall 10 cycles on byte 'b'
        push_basic();
        start_run(2);
        wait_valid(30);
        @(posedge clk);
        #1 out_ready = 1'b0;
        wait_valid(30);
        snap = {out_data, out_first, out_last, out_index, out_len, out_trunc};
        check("stall_byte", 128'({out_data, out_len}), 128'({8'h62, 6'd2}));
        repeat (10) begin
            @(negedge clk);
            check("stall_stable",
                  128'({out_valid, mem_rd_en, idx_rd_en, out_data, out_first, out_last,
                        out_index, out_len, out_trunc}),
                  128'({1'b1, 1'b0, 1'b0, snap}));
        end
        out_ready = 1'b1;
        wait_done(200);

        // Empty first password
        mem[16] = 8'h0A; mem[17] = "x"; mem[18] = "y"; mem[19] = 8'h00;
        itab[0] = 32'd16; itab[1] = 32'd17;
        push("x", 1'b1, 1'b0, 32'd1, 6'd1, 1'b0);
        push("y", 1'b0, 1'b1, 32'd1, 6'd2, 1'b0);
        start_run(2);
        wait_done(200);

        // Truncation at 55 of a 60-byte password
        for (int i = 0; i < 60; i++) mem[32 + i] = 8'h41 + 8'(i % 26);
        mem[92] = 8'h00;
        itab[0] = 32'd32;
        for (int i = 0; i < 55; i++)
            push(8'h41 + 8'(i % 26), i == 0, i == 54, 32'd0, 6'(i + 1), i == 54);
        start_run(1);
        wait_done(400);

        // Zero count after reset, ignored start, then full re-traversal
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_run(0);
        @(negedge clk);
        check("zero_count_done", 128'({done, busy}), 128'({1'b1, 1'b0}));
        table_ready = 1'b0;
        start_run(2);
        @(negedge clk);
        check("start_ignored_not_ready", 128'({done, busy, idx_rd_en}), 128'({1'b1, 1'b0, 1'b0}));
        table_ready = 1'b1;
        load_basic();
        push_basic();
        start_run(2);
        wait_done(200);

        // Reset during EMIT, then restart from entry 0
        out_ready = 1'b0;
        start_run(2);
        wait_valid(30);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_stream", all_outs(), 128'(0));
        exp_q.delete();
        rst = 1'b0;
        out_ready = 1'b1;
        push_basic();
        start_run(2);
        @(negedge clk);
        check("restart_idx0", 128'({idx_rd_en, idx_addr}), 128'({1'b1, 32'd0}));
        wait_done(200);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
